// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default widths for the UART TX scheduler.
// Holds the FSM state enum and the frame-source encoding.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  localparam logic SRC_SW = 1'b0;
  localparam logic SRC_FF = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/buf_occupancy.sv
// buf_occupancy: receive-buffer fill level and read pointer.
// Ports: clk, rst (async, active-low); inc (byte stored), dec (read
//   commit) in; rd_addr, count, overflow (sticky), empty_nxt out.
module buf_occupancy
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  empty_nxt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE =
    ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full;

  assign full = (count_q == FULL);

  always_comb begin
    count_d    = count_q;
    rd_addr_d  = rd_addr_q;
    // a store into a full buffer overwrites the oldest byte
    overflow_d = overflow_q | (inc & full);
    unique case ({inc, dec})
      2'b10: if (!full) count_d = count_q + ONE;
      2'b01: if (count_q != '0) count_d = count_q - ONE;
      default: ;
    endcase
    if (dec) rd_addr_d = rd_addr_q + A_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  // this commit takes the last buffered byte
  assign empty_nxt = dec & (count_d == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates one UART TX between the switch byte
// and the receive-buffer drain; owns the start/busy/done handshake.
// Ports: clk, rst (async, active-low); wr_we, req_sw, sw_data,
//   req_ff, ram_q, tx_busy, tx_done in; rd_addr, tx_start, tx_data,
//   busy, count, overflow, src out.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_we,
  input  logic                  req_sw,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic                  req_ff,
  input  logic [DATA_WIDTH-1:0] ram_q,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  src
);

  state_t                state_q, state_d;
  logic                  sw_pend_q, sw_pend_d;
  logic                  ff_pend_q, ff_pend_d;
  logic                  last_grant_q, last_grant_d;
  logic                  src_q, src_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic rd_commit;
  logic empty_nxt;
  logic not_empty;
  logic ff_elig;
  logic sw_go;
  logic ff_go;

  assign rd_commit = (state_q == FETCH);
  assign not_empty = (count != '0);
  assign ff_elig   = ff_pend_q & not_empty;

  buf_occupancy #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_occ (
    .clk      (clk),
    .rst      (rst),
    .inc      (wr_we),
    .dec      (rd_commit),
    .rd_addr  (rd_addr),
    .count    (count),
    .overflow (overflow),
    .empty_nxt(empty_nxt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    tx_data_d    = tx_data_q;
    sw_go        = 1'b0;
    ff_go        = 1'b0;
    // drain request sees the count before any same-cycle write
    ff_pend_d    = ff_pend_q | (req_ff & not_empty);
    if (empty_nxt) ff_pend_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // on contention serve the source that did not go last
        sw_go = sw_pend_q &
                (~ff_elig | (last_grant_q == SRC_FF));
        ff_go = ff_elig & ~sw_go;
        unique case (1'b1)
          sw_go: begin
            tx_data_d    = sw_data;
            src_d        = SRC_SW;
            last_grant_d = SRC_SW;
            state_d      = LOAD;
          end
          ff_go: begin
            src_d        = SRC_FF;
            last_grant_d = SRC_FF;
            state_d      = FETCH;
          end
          default: ;
        endcase
      end
      FETCH: begin
        tx_data_d = ram_q;
        state_d   = LOAD;
      end
      LOAD: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a request arriving in the grant cycle is a new request
    sw_pend_d = (sw_pend_q & ~sw_go) | req_sw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sw_pend_q    <= 1'b0;
      ff_pend_q    <= 1'b0;
      last_grant_q <= SRC_FF;
      src_q        <= SRC_SW;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      sw_pend_q    <= sw_pend_d;
      ff_pend_q    <= ff_pend_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx_start = (state_q == LOAD);
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);
  assign src      = src_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and randomized rounds against a
// frame-level model of arbitration, occupancy and RAM contents.
module tb_uart_tx_scheduler;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          wr_we;
  logic          req_sw;
  logic [DW-1:0] sw_data;
  logic          req_ff;
  logic [DW-1:0] ram_q;
  logic          tx_busy;
  logic          tx_done;
  logic [AW-1:0] rd_addr;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic [AW:0]   count;
  logic          overflow;
  logic          src;

  uart_tx_scheduler #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_we   (wr_we),
    .req_sw  (req_sw),
    .sw_data (sw_data),
    .req_ff  (req_ff),
    .ram_q   (ram_q),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .rd_addr (rd_addr),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .busy    (busy),
    .count   (count),
    .overflow(overflow),
    .src     (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receive buffer RAM and its write controller
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wr_data;
  int            wptr;

  always @(posedge clk) begin
    if (!rst) begin
      wptr  <= 0;
      ram_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_we) begin
        mem[wptr] <= wr_data;
        wptr      <= (wptr + 1) % DEPTH;
      end
      ram_q <= mem[rd_addr];
    end
  end

  // UART transmitter model
  bit         tx_en;
  logic       busy_m, done_m;
  logic       busy_x, done_x;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  assign tx_busy = busy_m | busy_x;
  assign tx_done = done_m | done_x;

  initial begin
    busy_m = 1'b0;
    done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && rst && tx_start === 1'b1 && !busy_m) begin
        got_q.push_back({src, tx_data});
        repeat ($urandom_range(0, 2)) @(negedge clk);
        busy_m = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        busy_m = 1'b0;
        done_m = 1'b1;
        @(negedge clk);
        done_m = 1'b0;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // reference model
  int m_count;
  int m_rd;
  bit m_ovf;
  bit m_last;

  task automatic model_reset();
    m_count = 0;
    m_rd    = 0;
    m_ovf   = 1'b0;
    m_last  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input bit rs, input bit rf,
                         input logic [DW-1:0] swv,
                         output int first);
    bit s, f, g;
    s     = rs;
    f     = rf && (m_count != 0);
    first = -1;
    exp_q.delete();
    while (s || f) begin
      if (s && f) g = ~m_last;
      else        g = f;
      if (first < 0) first = int'(g);
      if (!g) begin
        exp_q.push_back({1'b0, swv});
        s = 1'b0;
      end else begin
        exp_q.push_back({1'b1, mem[m_rd]});
        m_rd = (m_rd + 1) % DEPTH;
        m_count--;
        if (m_count == 0) f = 1'b0;
      end
      m_last = g;
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet, n;
    quiet = 0;
    n     = 0;
    while (quiet < 3 && n < 600) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) quiet++;
      else quiet = 0;
    end
    chk({tag, " idle"}, 32'(quiet >= 3), 32'd1);
  endtask

  task automatic check_end(input string tag);
    chk({tag, " nframes"}, 32'(got_q.size()),
        32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size())
        chk($sformatf("%s frame%0d", tag, i),
            32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, " count"}, 32'(count), 32'(m_count));
    chk({tag, " rd_addr"}, 32'(rd_addr), 32'(m_rd));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_writes(input int nw);
    for (int i = 0; i < nw; i++) begin
      wr_data = 8'($urandom);
      wr_we   = 1'b1;
      tick();
      if (m_count == DEPTH) m_ovf = 1'b1;
      else m_count++;
    end
    wr_we = 1'b0;
  endtask

  task automatic round(input string tag, input int nw,
                       input bit rs, input bit rf,
                       input logic [DW-1:0] swv);
    int first, lat;
    got_q.delete();
    do_writes(nw);
    sw_data = swv;
    req_sw  = rs;
    req_ff  = rf;
    tick();
    req_sw = 1'b0;
    req_ff = 1'b0;
    predict(rs, rf, swv, first);
    if (first >= 0) begin
      lat = (first == 1) ? 3 : 2;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        if (k == lat - 1)
          chk({tag, " start early"}, 32'(tx_start), 32'd0);
        if (k == lat)
          chk({tag, " start lat"}, 32'(tx_start), 32'd1);
      end
    end
    wait_idle(tag);
    check_end(tag);
  endtask

  initial begin
    int first;
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int first;
    rst     = 1'b0;
    wr_we   = 1'b0;
    wr_data = '0;
    req_sw  = 1'b0;
    req_ff  = 1'b0;
    sw_data = '0;
    busy_x  = 1'b0;
    done_x  = 1'b0;
    tx_en   = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst tx_start", 32'(tx_start), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst src", 32'(src), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    round("sw", 0, 1'b1, 1'b0, 8'h41);
    round("drain3", 3, 1'b0, 1'b1, 8'h00);
    round("rr", 2, 1'b1, 1'b1, 8'h5c);
    round("fill9", 9, 1'b0, 1'b0, 8'h00);
    round("drain8", 0, 1'b0, 1'b1, 8'h00);
    round("wrap", 2, 1'b0, 1'b1, 8'h00);
    round("empty", 0, 1'b0, 1'b1, 8'h00);

    // stray handshake inputs while idle
    tx_en  = 1'b0;
    done_x = 1'b1;
    busy_x = 1'b1;
    tick();
    done_x = 1'b0;
    busy_x = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray busy", 32'(busy), 32'd0);
    chk("stray count", 32'(count), 32'(m_count));
    tx_en = 1'b1;
    tick();

    // drain request alongside the first write: dropped
    got_q.delete();
    wr_data = 8'($urandom);
    wr_we   = 1'b1;
    req_ff  = 1'b1;
    tick();
    wr_we  = 1'b0;
    req_ff = 1'b0;
    m_count++;
    wait_idle("wr_ff");
    exp_q.delete();
    check_end("wr_ff");
    round("drain1", 0, 1'b0, 1'b1, 8'h00);

    // write landing on the read-commit edge
    got_q.delete();
    do_writes(2);
    req_ff = 1'b1;
    tick();
    req_ff = 1'b0;
    tick();
    wr_data = 8'($urandom);
    wr_we   = 1'b1;
    tick();
    wr_we = 1'b0;
    @(negedge clk);
    chk("commit+wr count", 32'(count), 32'(m_count));
    m_count++;
    wait_idle("commit+wr");
    predict(1'b0, 1'b1, 8'h00, first);
    check_end("commit+wr");

    // reset while a frame is being offered
    tx_en = 1'b0;
    tick();
    sw_data = 8'h5a;
    req_sw  = 1'b1;
    tick();
    req_sw = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-rst tx_start", 32'(tx_start), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst tx_start", 32'(tx_start), 32'd0);
    chk("arst tx_data", 32'(tx_data), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst count", 32'(count), 32'd0);
    chk("arst overflow", 32'(overflow), 32'd0);
    chk("arst rd_addr", 32'(rd_addr), 32'd0);
    chk("arst src", 32'(src), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    tx_en = 1'b1;
    tick();
    round("post-rst", 0, 1'b1, 1'b0, 8'h33);

    for (int r = 0; r < 40; r++) begin
      round($sformatf("rnd%0d", r),
            $urandom_range(0, DEPTH - m_count),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequences and arbitrates the single UART transmitter between two requesters: the switch path (one immediate byte) and the 8-entry receive buffer RAM (drain of stored bytes). It tracks buffer occupancy from the write controller's strobes and generates the RAM read address. It also runs the start/busy/done handshake with the TX, so at most one frame is in flight. It replaces the separate read-control and one-pulse glue between the RAM, the mode selector and the TX.

## Interface
- DATA_WIDTH, 8, byte width of RAM and TX data
- ADDR_WIDTH, 3, RAM address width; DEPTH = 2**ADDR_WIDTH
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_we  in  1  write strobe from write controller, one clk per stored byte
- req_sw  in  1  one-clk pulse: send sw_data once
- sw_data  in  DATA_WIDTH  switch byte, sampled at switch grant
- req_ff  in  1  one-clk pulse: drain every byte currently buffered
- ram_q  in  DATA_WIDTH  RAM read data, valid 1 clk after rd_addr
- tx_busy  in  1  TX frame in progress (acknowledges tx_start)
- tx_done  in  1  one-clk pulse at end of stop bit
- rd_addr  out  ADDR_WIDTH  RAM read pointer
- tx_start  out  1  request to TX, held until tx_busy seen
- tx_data  out  DATA_WIDTH  registered byte for TX, stable while tx_start or WAIT_DONE
- busy  out  1  state != IDLE
- count  out  ADDR_WIDTH+1  buffered bytes, 0..DEPTH
- overflow  out  1  sticky: write arrived with count == DEPTH
- src  out  1  source of current/last frame: 0 = switch, 1 = buffer

## Operation
- Reset values: rd_addr 0, tx_start 0, tx_data 0, busy 0, count 0, overflow 0, src 0, sw_pend 0, ff_pend 0, last_grant = FF, state IDLE.
- Pending latches: req_sw sets sw_pend; req_ff sets ff_pend only if count != 0 (otherwise dropped). Repeated requests while pending merge.
- Occupancy: count +1 on wr_we, −1 on read commit (FETCH exit); both in the same clk leaves count unchanged. A write at count == DEPTH sets overflow and leaves count at DEPTH (the overwritten byte is lost). overflow clears only on reset.
- rd_addr increments mod DEPTH on each read commit (7 → 0).
- ff_pend clears when a read commit brings count to 0.
- FSM states: IDLE, FETCH, LOAD, WAIT_DONE.
  - IDLE: the ff request is eligible when ff_pend and count != 0.
    - If only sw is pending: grant sw, capture sw_data into tx_data, clear sw_pend, src 0, go to LOAD.
    - If only ff is eligible: grant ff, src 1, go to FETCH.
    - If both: round-robin; grant the source opposite last_grant. last_grant updates on every grant.
  - FETCH (1 clk): capture ram_q into tx_data, commit read, go to LOAD.
  - LOAD: tx_start = 1; on tx_busy = 1 drop tx_start and go to WAIT_DONE.
  - WAIT_DONE: on tx_done, return to IDLE. Re-arbitration happens per byte, so a switch request interleaves with a drain.
- tx_done outside WAIT_DONE is ignored. tx_busy in IDLE/FETCH is ignored.

## Timing
- Switch path: req_sw at cycle n → tx_start high at n+2 (latch at n+1, grant at n+1 with state LOAD registered).
- Buffer path: req_ff at n → FETCH at n+2 → tx_start high at n+3.
- Between frames: tx_done at cycle m → IDLE at m+1 → the next grant is evaluated at m+1.
- tx_start never drops without tx_busy, except on reset.
- Reset mid-frame: immediate return to all reset values; the in-flight TX frame is not tracked.
- Simultaneous req_ff and wr_we with count 0: req_ff is dropped, because it sees the pre-write count.

## Structure
- Shared package uart_pkg:
  - state enum {IDLE, FETCH, LOAD, WAIT_DONE}
  - SRC_SW = 0, SRC_FF = 1
  - default DATA_WIDTH/ADDR_WIDTH constants
- One sub-module, buf_occupancy: count, overflow and rd_addr pointer, with inputs inc/dec.
- Arbiter and FSM live in the top of this block.

## Test plan
- Switch send: sw_data 0x41, req_sw pulse → tx_start at +2 clk with tx_data 0x41, src 0; tx_busy ack drops tx_start; tx_done → busy 0.
- Drain: 3 writes (count 3), req_ff → three frames with rd_addr 0, 1, 2 and tx_data equal to the RAM bytes; count 3→0, ff_pend cleared, busy 0 after third tx_done.
- Round-robin: 2 buffered bytes, req_ff and req_sw in the same clk → order FF? No: last_grant reset FF, so sw first, then ff, then ff; src sequence 0, 1, 1.
- Wrap/overflow: 9 writes with no drain → count 8, overflow 1. Drain 8 bytes, then 2 more writes and a drain → rd_addr wraps 7 → 0 → 1.
- Empty/ignored: req_ff at count 0 → no tx_start. Stray tx_done in IDLE → no state change. Simultaneous wr_we and read commit → count unchanged.
- Reset in LOAD: assert rst while tx_start = 1 → all outputs 0 asynchronously. After release, a new req_sw is served normally.
